// File: rtl/frame_buffer_pkg.sv
// Shared types and frame geometry for the frame-buffer read path.
package frame_buffer_pkg;

  typedef logic [23:0] pixel_t;
  typedef logic [16:0] addr_t;
  typedef logic [8:0]  xcoord_t;
  typedef logic [7:0]  ycoord_t;

  localparam int FRAME_W      = 320;
  localparam int FRAME_H      = 240;
  localparam int FRAME_PIXELS = FRAME_W * FRAME_H;
  localparam addr_t LAST_ADDR = addr_t'(FRAME_PIXELS - 1);

  typedef struct packed {
    logic sof;
    logic eol;
    logic eof;
  } pix_tag_t;

  typedef struct packed {
    pixel_t   pix;
    pix_tag_t tag;
  } fifo_entry_t;

  typedef struct packed {
    logic     valid;
    pix_tag_t tag;
  } tag_beat_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    LAST
  } reader_state_t;

endpackage

// File: rtl/scanout_skid_fifo.sv
// First-word-fall-through skid FIFO: a registered output stage backed by a
// DEPTH-1 entry ring, so total capacity is DEPTH and the head is always a flop.
module scanout_skid_fifo
  import frame_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       push_i,
  input  fifo_entry_t                push_data_i,
  input  logic                       ready_i,
  output logic                       valid_o,
  output fifo_entry_t                data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int RING = DEPTH - 1;
  localparam int PW   = (RING > 1) ? $clog2(RING) : 1;
  localparam int CW   = $clog2(DEPTH + 1);

  fifo_entry_t   mem_q [RING];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] ring_cnt_q, ring_cnt_d;
  fifo_entry_t   out_q, out_d;
  logic          out_valid_q, out_valid_d;
  logic          pop, load_out, take_ring, bypass, ring_wr;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(RING - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: every variable gets its default at the top of always_comb so no path can infer a latch.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    pop         = out_valid_q & ready_i;
    load_out    = ~out_valid_q | pop;
    take_ring   = load_out & (ring_cnt_q != '0);
    // An empty ring lets a push land straight in the output stage.
    bypass      = load_out & (ring_cnt_q == '0) & push_i;
    ring_wr     = push_i & ~bypass;
    if (load_out) begin
      out_valid_d = take_ring | bypass;
      if (take_ring) begin
        out_d = mem_q[rd_ptr_q];
      end else if (bypass) begin
        out_d = push_data_i;
      end
    end
    wr_ptr_d   = ring_wr ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = take_ring ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    ring_cnt_d = ring_cnt_q + CW'(ring_wr) - CW'(take_ring);
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ring_cnt_q  <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ring_cnt_q  <= ring_cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  // NOTE: storage is not reset; the pointers and count decide which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (ring_wr) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign valid_o = out_valid_q;
  assign data_o  = out_q;
  assign count_o = CW'(out_valid_q) + ring_cnt_q;

endmodule

// File: rtl/frame_scanout_reader.sv
// Raster-order read master for one 320x240 frame with latency absorption and a
// valid/ready pixel stream. Define FRAME_SCANOUT_STATS_EN to enable stall counting.
module frame_scanout_reader
  import frame_buffer_pkg::*;
#(
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        enable_i,
  output logic        read_en_o,
  output logic [16:0] read_addr_o,
  input  logic [23:0] rd_pixel_i,
  output logic [23:0] pix_data_o,
  output logic        pix_valid_o,
  input  logic        pix_ready_i,
  output logic        pix_sof_o,
  output logic        pix_eol_o,
  output logic        pix_eof_o,
  output logic        busy_o,
  output logic [15:0] stall_cnt_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  reader_state_t state_q, state_d;
  addr_t         addr_q, addr_d;
  xcoord_t       x_q, x_d;
  ycoord_t       y_q, y_d;
  logic          read_en_q, read_en_d;
  addr_t         read_addr_q, read_addr_d;
  pix_tag_t      issue_tag_q, issue_tag_d;
  tag_beat_t     pipe_q [READ_LATENCY];

  fifo_entry_t   push_entry, head;
  logic [CW-1:0] fifo_count;
  logic [7:0]    occupancy;
  logic          inflight_any, pop, credit_ok, issue;

  assign pop = pix_valid_o & pix_ready_i;

  // Everything already issued but not yet handed downstream holds a FIFO slot.
  always_comb begin
    occupancy    = 8'(read_en_q) + 8'(fifo_count);
    inflight_any = read_en_q;
    for (int i = 0; i < READ_LATENCY; i++) begin
      occupancy    = occupancy + 8'(pipe_q[i].valid);
      inflight_any = inflight_any | pipe_q[i].valid;
    end
    credit_ok = (int'(occupancy) - int'(pop)) < FIFO_DEPTH;
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    x_d             = x_q;
    y_d             = y_q;
    issue           = 1'b0;
    issue_tag_d.sof = (addr_q == '0);
    issue_tag_d.eol = (x_q == xcoord_t'(FRAME_W - 1));
    issue_tag_d.eof = (addr_q == LAST_ADDR);
    unique case (state_q)
      IDLE: if (enable_i) state_d = RUN;
      RUN: begin
        if (credit_ok) begin
          issue = 1'b1;
          if (addr_q == LAST_ADDR) begin
            state_d = LAST;
            addr_d  = '0;
            x_d     = '0;
            y_d     = '0;
          end else begin
            addr_d = addr_q + 1'b1;
            if (x_q == xcoord_t'(FRAME_W - 1)) begin
              x_d = '0;
              y_d = (y_q == ycoord_t'(FRAME_H - 1)) ? '0 : y_q + 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
          end
        end
      end
      // Enable is only sampled at the frame boundary, so frames are never cut short.
      LAST:    state_d = enable_i ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
    read_en_d   = issue;
    read_addr_d = issue ? addr_q : read_addr_q;
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      read_en_q   <= 1'b0;
      read_addr_q <= '0;
      issue_tag_q <= '0;
      for (int i = 0; i < READ_LATENCY; i++) pipe_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      x_q         <= x_d;
      y_q         <= y_d;
      read_en_q   <= read_en_d;
      read_addr_q <= read_addr_d;
      issue_tag_q <= issue_tag_d;
      pipe_q[0]   <= '{valid: read_en_q, tag: issue_tag_q};
      for (int i = 1; i < READ_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  // The tap lines up with rd_pixel for the address issued READ_LATENCY cycles ago.
  assign push_entry = '{pix: rd_pixel_i, tag: pipe_q[READ_LATENCY-1].tag};

  scanout_skid_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .push_i      (pipe_q[READ_LATENCY-1].valid),
    .push_data_i (push_entry),
    .ready_i     (pix_ready_i),
    .valid_o     (pix_valid_o),
    .data_o      (head),
    .count_o     (fifo_count)
  );

  assign read_en_o   = read_en_q;
  assign read_addr_o = read_addr_q;
  assign pix_data_o  = head.pix;
  assign pix_sof_o   = pix_valid_o & head.tag.sof;
  assign pix_eol_o   = pix_valid_o & head.tag.eol;
  assign pix_eof_o   = pix_valid_o & head.tag.eof;
  assign busy_o      = (state_q != IDLE) | inflight_any | (fifo_count != '0);

`ifdef FRAME_SCANOUT_STATS_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (pop && pix_sof_o) begin
      stall_d = '0;
    end else if (pix_valid_o && !pix_ready_i && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) stall_q <= '0;
    else           stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = 16'h0;
`endif

endmodule

// File: tb/tb_frame_scanout_reader.sv
// Self-checking bench for frame_scanout_reader against a raster-order pixel model.
module tb_frame_scanout_reader;

  localparam int NPIX  = 320 * 240;
  localparam int DEPTH = 4;
`ifdef FRAME_SCANOUT_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        reset_ni, enable_i, pix_ready_i;
  logic        read_en_o, pix_valid_o, pix_sof_o, pix_eol_o, pix_eof_o, busy_o;
  logic [16:0] read_addr_o;
  logic [23:0] rd_pixel_i, pix_data_o;
  logic [15:0] stall_cnt_o;

  frame_scanout_reader dut (
    .clk_i       (clk_i),
    .reset_ni    (reset_ni),
    .enable_i    (enable_i),
    .read_en_o   (read_en_o),
    .read_addr_o (read_addr_o),
    .rd_pixel_i  (rd_pixel_i),
    .pix_data_o  (pix_data_o),
    .pix_valid_o (pix_valid_o),
    .pix_ready_i (pix_ready_i),
    .pix_sof_o   (pix_sof_o),
    .pix_eol_o   (pix_eol_o),
    .pix_eof_o   (pix_eof_o),
    .busy_o      (busy_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Frame-buffer content: mode 0 encodes the address, mode 1 is three colour bars.
  bit data_mode = 1'b1;
  function automatic logic [23:0] pix_of(input bit mode, input int a);
    if (!mode)        return {7'h35, 17'(a)};
    if (a < 25600)    return 24'hFF0000;
    if (a < 51200)    return 24'h00FF00;
    return 24'h0000FF;
  endfunction

  // Buffer with a fixed two-cycle read latency.
  logic [16:0] a1_q, a2_q;
  always @(posedge clk_i) begin
    a1_q <= read_addr_o;
    a2_q <= a1_q;
  end
  assign rd_pixel_i = pix_of(data_mode, int'(a2_q));

  int total = 0, bad = 0;
  int cyc = 0;
  int exp_addr = 0, exp_issue = 0, issued = 0, accepted = 0, exp_stall = 0;
  int first_rd = -1, first_pv = -1;
  bit eof_seen = 0, held_v = 0;
  logic [26:0] held;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive ready, check the current cycle against the model, advance.
  task automatic tick(input bit rdy);
    bit hs;
    logic [26:0] cur;
    pix_ready_i = rdy;
    cur = {pix_sof_o, pix_eol_o, pix_eof_o, pix_data_o};
    hs  = pix_valid_o && rdy;
    if (held_v) begin
      chk("hold_valid", 32'(pix_valid_o), 1);
      chk("hold_data", 32'(cur), 32'(held));
    end
    if (read_en_o) begin
      chk("read_addr", 32'(read_addr_o), exp_issue);
      exp_issue = (exp_issue == NPIX - 1) ? 0 : exp_issue + 1;
      issued++;
      if (first_rd < 0) first_rd = cyc;
    end
    chk("outstanding", 32'(issued - accepted <= DEPTH), 1);
    chk("stall_cnt", 32'(stall_cnt_o), exp_stall);
    if (pix_valid_o && first_pv < 0) first_pv = cyc;
    if (hs) begin
      chk("pixel", 32'(cur), 32'({exp_addr == 0, (exp_addr % 320) == 319,
                                  exp_addr == NPIX - 1, pix_of(data_mode, exp_addr)}));
      if (exp_addr == NPIX - 1) eof_seen = 1;
      accepted++;
    end
    if (STATS_ON) begin
      if (hs && exp_addr == 0) exp_stall = 0;
      else if (pix_valid_o && !rdy && exp_stall != 16'hFFFF) exp_stall++;
    end
    if (hs) exp_addr = (exp_addr == NPIX - 1) ? 0 : exp_addr + 1;
    held_v = pix_valid_o && !rdy;
    held   = cur;
    @(posedge clk_i);
    #1;
    cyc++;
  endtask

  function automatic bit in_window(input int n);
    return (n < 600) || (n >= 25400 && n < 25800) || (n >= 51000 && n < 51400);
  endfunction

  task automatic check_all_zero(input string tag);
    chk({tag, "_read_en"}, 32'(read_en_o), 0);
    chk({tag, "_read_addr"}, 32'(read_addr_o), 0);
    chk({tag, "_valid"}, 32'(pix_valid_o), 0);
    chk({tag, "_data"}, 32'(pix_data_o), 0);
    chk({tag, "_tags"}, 32'({pix_sof_o, pix_eol_o, pix_eof_o}), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_stall"}, 32'(stall_cnt_o), 0);
  endtask

  initial begin
    int guard, rd_cnt;
    bit stalled;
    reset_ni    = 1'b0;
    enable_i    = 1'b0;
    pix_ready_i = 1'b0;
    #12;
    check_all_zero("reset");
    @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    tick(0);
    tick(0);
    chk("idle_busy", 32'(busy_o), 0);

    // Frame 1: colour bars, random backpressure across bar boundaries,
    // one long mid-line stall, enable dropped early in the frame.
    enable_i = 1'b1;
    guard    = 0;
    stalled  = 0;
    while (!eof_seen && guard < 82000) begin
      if (!stalled && accepted == 3000) begin
        stalled = 1;
        rd_cnt  = 0;
        for (int i = 0; i < 100; i++) begin
          if (i >= 10 && read_en_o) rd_cnt++;
          tick(0);
        end
        chk("stall_no_issue", rd_cnt, 0);
      end else begin
        if (exp_issue > 1000) enable_i = 1'b0;
        tick(in_window(accepted) ? 1'($urandom_range(0, 1)) : 1'b1);
        guard++;
      end
    end
    chk("frame1_eof", 32'(eof_seen), 1);
    chk("frame1_count", accepted, NPIX);
    for (int i = 0; i < 4; i++) tick(1);
    chk("after_frame_busy", 32'(busy_o), 0);
    chk("after_frame_valid", 32'(pix_valid_o), 0);
    for (int i = 0; i < 5; i++) begin
      chk("after_frame_read_en", 32'(read_en_o), 0);
      tick(1);
    end

    // Frame 2: address-encoded data, latency check, 37-cycle stall, then reset mid-frame.
    data_mode = 1'b0;
    first_rd  = -1;
    first_pv  = -1;
    eof_seen  = 0;
    enable_i  = 1'b1;
    guard     = 0;
    while (first_pv < 0 && guard < 20) begin
      tick(1);
      guard++;
    end
    chk("first_valid_latency", 32'(first_pv - first_rd), 3);
    chk("second_pixel_valid", 32'(pix_valid_o), 1);
    for (int i = 0; i < 37; i++) tick(0);
    chk("stall37", 32'(stall_cnt_o), STATS_ON ? 37 : 0);
    guard = 0;
    while (exp_issue < 2000 && guard < 3000) begin
      tick(1);
      guard++;
    end
    chk("busy_before_reset", 32'(busy_o), 1);
    chk("read_en_before_reset", 32'(read_en_o), 1);
    reset_ni = 1'b0;
    #1;
    check_all_zero("midframe_reset");
    exp_addr  = 0;
    exp_issue = 0;
    issued    = 0;
    accepted  = 0;
    exp_stall = 0;
    held_v    = 0;
    @(posedge clk_i);
    #1;
    reset_ni = 1'b1;
    guard    = 0;
    while (!pix_valid_o && guard < 20) begin
      tick(0);
      guard++;
    end
    chk("post_reset_valid", 32'(pix_valid_o), 1);
    chk("post_reset_sof", 32'(pix_sof_o), 1);
    chk("post_reset_data", 32'(pix_data_o), 32'(pix_of(1'b0, 0)));
    for (int i = 0; i < 300; i++) tick(1'($urandom_range(0, 1)));
    chk("post_reset_progress", 32'(accepted > 50), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
